// File: rtl/pc_gen.sv
// Program-counter generation stage feeding the IF/ID fetch register.
// Advances by 4 on each fetch accept and applies branch/jump/trap redirects, buffering a redirect that arrives while fetch is busy.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        pc_b_j,
  output logic        misalign
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] pend_pc;
  logic        accept;
  logic        load;
  logic [31:0] load_pc;

  assign pc_valid = (state == RUN) || (state == HOLD);
  assign accept   = pc_valid & fetch_ready & ~stall;

  // In HOLD a redirect arriving together with accept bypasses pend_pc (newest wins).
  always_comb begin
    load    = 1'b0;
    load_pc = redirect_pc;
    case (state)
      RUN:  load = redirect_valid & accept;
      HOLD: begin
        load = accept;
        if (!redirect_valid) load_pc = pend_pc;
      end
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      pend_pc  <= '0;
      pc_b_j   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (load) begin
        pc       <= {load_pc[31:2], 2'b00};
        pc_b_j   <= 1'b1;
        misalign <= |load_pc[1:0];
        state    <= RUN;
      end else if (accept) begin
        pc     <= pc + 32'd4;
        pc_b_j <= 1'b0;
      end

      // A redirect that cannot be taken yet is parked, even under stall.
      case (state)
        BOOT: begin
          if (redirect_valid) begin
            pend_pc <= redirect_pc;
            state   <= HOLD;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (redirect_valid && !accept) begin
            pend_pc <= redirect_pc;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid && !accept) pend_pc <= redirect_pc;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen: each step drives inputs, queues the expected
// post-edge outputs, then pops and checks them one time unit after the rising edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_b_j;
  logic        misalign;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        bj;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  always #5 clk = ~clk;

  pc_gen #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_ready    (fetch_ready),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .pc_b_j         (pc_b_j),
    .misalign       (misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic step(input logic r, input logic fr, input logic st, input logic rv,
                      input logic [31:0] rpc, input string tag, input logic ev,
                      input logic [31:0] epc, input logic ebj, input logic emis);
    exp_t e;
    rst            = r;
    fetch_ready    = fr;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    e.tag = tag; e.pc = epc; e.valid = ev; e.bj = ebj; e.mis = emis;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({e.tag, ".valid"}, {31'd0, pc_valid}, {31'd0, e.valid});
    if (e.valid) chk({e.tag, ".pc"}, pc, e.pc);
    chk({e.tag, ".pc_b_j"}, {31'd0, pc_b_j}, {31'd0, e.bj});
    chk({e.tag, ".misalign"}, {31'd0, misalign}, {31'd0, e.mis});
  endtask

  initial begin
    rst = 1'b1; fetch_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    //   rst fr st rv rpc            tag        valid pc             bj mis
    step(1, 0, 0, 0, 32'h0,         "rst0",    0, 32'h8000_0000, 0, 0);
    step(1, 0, 0, 0, 32'h0,         "rst1",    0, 32'h8000_0000, 0, 0);
    chk("rst.pc", pc, 32'h8000_0000);
    step(0, 1, 0, 0, 32'h0,         "boot",    1, 32'h8000_0000, 0, 0);
    step(0, 1, 0, 0, 32'h0,         "seq1",    1, 32'h8000_0004, 0, 0);
    step(0, 1, 0, 0, 32'h0,         "seq2",    1, 32'h8000_0008, 0, 0);
    step(0, 1, 0, 0, 32'h0,         "seq3",    1, 32'h8000_000C, 0, 0);
    step(0, 1, 0, 0, 32'h0,         "seq4",    1, 32'h8000_0010, 0, 0);
    step(0, 1, 0, 1, 32'h8000_0100, "redir",   1, 32'h8000_0100, 1, 0);
    step(0, 1, 0, 0, 32'h0,         "redir+4", 1, 32'h8000_0104, 0, 0);
    step(0, 0, 0, 1, 32'h8000_0200, "buf1",    1, 32'h8000_0104, 0, 0);
    step(0, 0, 0, 0, 32'h0,         "buf2",    1, 32'h8000_0104, 0, 0);
    step(0, 0, 0, 1, 32'h8000_0300, "bufow",   1, 32'h8000_0104, 0, 0);
    step(0, 1, 0, 0, 32'h0,         "buftake", 1, 32'h8000_0300, 1, 0);
    step(0, 1, 0, 0, 32'h0,         "buf+4",   1, 32'h8000_0304, 0, 0);
    step(0, 1, 1, 0, 32'h0,         "stall1",  1, 32'h8000_0304, 0, 0);
    step(0, 1, 1, 1, 32'h8000_0402, "stall2",  1, 32'h8000_0304, 0, 0);
    step(0, 1, 1, 0, 32'h0,         "stall3",  1, 32'h8000_0304, 0, 0);
    step(0, 1, 0, 0, 32'h0,         "misal",   1, 32'h8000_0400, 1, 1);
    step(0, 1, 0, 0, 32'h0,         "misal+4", 1, 32'h8000_0404, 0, 0);
    step(0, 1, 0, 1, 32'hFFFF_FFFC, "wrapld",  1, 32'hFFFF_FFFC, 1, 0);
    step(0, 1, 0, 0, 32'h0,         "wrap0",   1, 32'h0000_0000, 0, 0);
    step(0, 1, 0, 0, 32'h0,         "wrap4",   1, 32'h0000_0004, 0, 0);
    step(0, 0, 0, 1, 32'h0000_1234, "hold",    1, 32'h0000_0004, 0, 0);
    step(1, 0, 0, 0, 32'h0,         "rsthold", 0, 32'h8000_0000, 0, 0);
    step(0, 1, 0, 0, 32'h0,         "reboot",  1, 32'h8000_0000, 0, 0);
    step(0, 1, 0, 0, 32'h0,         "nopend",  1, 32'h8000_0004, 0, 0);
    step(0, 0, 0, 1, 32'h8000_0500, "hold2",   1, 32'h8000_0004, 0, 0);
    step(0, 1, 0, 1, 32'h8000_0601, "bypass",  1, 32'h8000_0600, 1, 1);
    step(0, 1, 0, 0, 32'h0,         "byp+4",   1, 32'h8000_0604, 0, 0);
    step(0, 0, 0, 0, 32'h0,         "idle",    1, 32'h8000_0604, 0, 0);
    step(0, 1, 0, 1, 32'h8000_0700, "b2b1",    1, 32'h8000_0700, 1, 0);
    step(0, 1, 0, 1, 32'h8000_0800, "b2b2",    1, 32'h8000_0800, 1, 0);
    step(0, 1, 0, 0, 32'h0,         "b2b+4",   1, 32'h8000_0804, 0, 0);
    step(0, 1, 0, 1, 32'h0,         "bootrd0", 1, 32'h0000_0000, 1, 0);
    step(1, 0, 0, 0, 32'h0,         "rst2",    0, 32'h8000_0000, 0, 0);
    step(0, 1, 0, 1, 32'h8000_0900, "bootrd",  1, 32'h8000_0000, 0, 0);
    step(0, 1, 0, 0, 32'h0,         "bootrd2", 1, 32'h8000_0900, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generation stage sitting directly upstream of the IF/ID fetch register. It holds the current fetch address, presents it to the fetch stage, and advances it by 4 whenever fetch accepts it. Control-flow redirects (branch, jump, trap) from execute override sequential flow. A redirect that arrives while fetch is busy is buffered until fetch can take it.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetch_ready  in  1  fetch stage can accept `pc` this cycle (driven from fetch `out_ready`).
- stall  in  1  global pipeline stall; blocks acceptance.
- redirect_valid  in  1  one-cycle request to change flow.
- redirect_pc  in  32  redirect target.
- pc  out  32  current fetch address (drives fetch `in_pc`).
- pc_valid  out  1  `pc` is meaningful.
- pc_b_j  out  1  `pc` was loaded from a redirect and has not yet been accepted.
- misalign  out  1  one-cycle pulse: an accepted redirect target had bits [1:0] != 0.

## Operation
- accept = pc_valid & fetch_ready & ~stall.
- State machine BOOT / RUN / HOLD; state, pc, pend_pc, pc_b_j and misalign are all registers.
- **Reset** (rst=1 at an edge): state=BOOT, pc=RESET_PC, pend_pc=0, pc_valid=0, pc_b_j=0, misalign=0. Any pending redirect is discarded.
- **BOOT**
  - pc_valid=0.
  - Next cycle: RUN.
  - A redirect_valid seen in BOOT is latched as in HOLD, and the state goes to HOLD.
- **RUN** (pc_valid=1)
  - redirect_valid & accept: pc<=redirect_pc & ~3, pc_b_j<=1.
  - redirect_valid & ~accept: pend_pc<=redirect_pc, next state HOLD. `pc` is unchanged so the in-flight fetch address stays stable.
  - ~redirect_valid & accept: pc<=pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), pc_b_j<=0.
  - Otherwise: hold all state.
- **HOLD** (pc_valid=1; `pc` is still the old, not-yet-accepted address)
  - accept: pc<=pend_pc & ~3, pc_b_j<=1, next state RUN.
  - A new redirect_valid in HOLD overwrites pend_pc; the newest redirect wins. If it coincides with accept, redirect_pc is loaded directly, bypassing pend_pc.
  - No sequential +4 advance happens while in HOLD.
- **misalign**: asserted for one cycle in the cycle after a redirect target with bits [1:0] != 0 is loaded into pc; the target is forced to word alignment.
- pc_b_j clears on the first accept after it was set, unless that accept also loads a redirect.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset release: first cycle with pc_valid=1 and pc=RESET_PC is 1 cycle after rst falls (BOOT lasts one cycle).
- Sequential throughput: one address per cycle while accept=1.
- Redirect latency:
  - Redirect with accept in cycle N: pc=target in cycle N+1.
  - Redirect without accept: target appears the cycle after the first accept.
- stall=1 freezes pc, state and pc_b_j. Redirects are still latched into pend_pc.
- rst has priority over every other input, including mid-HOLD.

## Test plan
- **Reset/boot:** hold rst 2 cycles, release, fetch_ready=1 -> pc_valid 0 for 1 cycle, then pc=0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles; pc_b_j=0.
- **Immediate redirect:** at pc=0x8000_0010 apply redirect_valid=1, redirect_pc=0x8000_0100, fetch_ready=1 -> next pc=0x8000_0100, pc_b_j=1 for one cycle, then 0x8000_0104 with pc_b_j=0.
- **Buffered redirect and overwrite:**
  - Apply fetch_ready=0, redirect to 0x8000_0200; two cycles later redirect to 0x8000_0300 -> pc stays at the old value.
  - Then raise fetch_ready -> pc=0x8000_0300 with pc_b_j=1; 0x200 is never issued.
- **Stall plus misalignment:** stall=1 with fetch_ready=1 for 3 cycles -> pc frozen. Redirect to 0x8000_0402 during the stall, then drop stall -> pc=0x8000_0400, misalign pulse 1 cycle.
- **Wrap and reset mid-HOLD:**
  - Redirect to 0xFFFF_FFFC, accept twice -> pc=0x0000_0000.
  - Enter HOLD with target 0x1234, assert rst -> pc=0x8000_0000 after boot and the pending target is discarded.
